instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: i_clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: o_imem_addr  output  32  instruction memory word address.
REQ-005 SHALL have port: o_imem_req  output  1  fetch request.
REQ-006 SHALL have port: i_imem_ack  input  1  request complete; i_imem_rdata valid this cycle.
REQ-007 SHALL have port: i_imem_rdata  input  32  fetched instruction.
REQ-008 SHALL have port: i_redirect  input  1  branch/jump taken; refetch from i_redirect_pc.
REQ-009 SHALL have port: i_redirect_pc  input  32  redirect target.
REQ-010 SHALL have port: o_instruction  output  32  instruction to decode/immediate stage.
REQ-011 SHALL have port: o_pc  output  32  address of o_instruction.
REQ-012 SHALL have port: o_valid  output  1  o_instruction/o_pc valid.
REQ-013 SHALL have port: i_ready  input  1  decode accepts; transfer when o_valid & i_ready.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, STALL, DRAIN.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then go to FETCH; i_imem_ack in IDLE SHALL be ignored.
REQ-016 o_imem_req SHALL be 1 in FETCH and DRAIN only; o_imem_addr and o_imem_req SHALL stay stable until the cycle i_imem_ack=1.
REQ-017 On ack in FETCH, {i_imem_rdata, fetch PC} SHALL be pushed into a 2-entry output buffer and fetch PC SHALL advance by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 A new request SHALL issue only if buffer occupancy after this cycle's push/pop is below 2; otherwise FETCH->STALL; STALL->FETCH when occupancy drops below 2.
REQ-019 Back-to-back acks with i_ready=1 SHALL sustain one instruction per cycle.
REQ-020 o_valid SHALL equal buffer non-empty; o_instruction/o_pc SHALL show the oldest entry, stable while o_valid & !i_ready.
REQ-021 Buffer push and pop in the same cycle SHALL both take effect; pointers wrap modulo 2.
REQ-022 On i_redirect with no outstanding request (STALL, or FETCH with ack the same cycle): buffer flushed, fetch PC = {i_redirect_pc[31:2],2'b00}, next state FETCH; the ack's data SHALL be discarded.
REQ-023 On i_redirect in FETCH without ack: buffer flushed, target latched, state DRAIN; DRAIN holds old address until ack, discards data, then fetch PC = latched target, state FETCH.
REQ-024 A second i_redirect in DRAIN SHALL overwrite the latched target.
REQ-025 A transfer (o_valid & i_ready) in a redirect cycle SHALL count as consumed; o_valid SHALL be 0 the cycle after any redirect.
REQ-026 Redirect target low two bits SHALL be forced to 0.

Reset
REQ-027 While i_rst_n=0: state IDLE, fetch PC=RESET_PC, o_imem_addr=RESET_PC, o_imem_req=0, buffer empty, o_valid=0, o_instruction=0, o_pc=0, latched target=0.
REQ-028 Reset asserted mid-request SHALL abandon it; a late ack arriving in IDLE SHALL be ignored.

Structure
REQ-029 Shared package SHALL hold FSM state encoding, instruction/address width (32), RESET_PC default and PC increment (4).
REQ-030 The 2-entry output buffer SHALL be a sub-module fetch_buffer (push, pop, count, data/pc out, flush).

Verification
REQ-031 Reset release, ack every cycle, i_ready=1 -> o_pc 0,4,8,... one per cycle; first o_valid within 3 cycles of reset release.
REQ-032 i_ready=0 with acks -> exactly 2 entries buffered, o_imem_req drops to 0 (STALL), o_instruction stable; i_ready=1 -> both drained in order, then fetch resumes at PC 8.
REQ-033 Redirect to 32'h0000_0103 in FETCH, ack delayed 3 cycles -> old address held, that data discarded, next o_imem_addr=32'h0000_0100, first output o_pc=32'h100.
REQ-034 Redirect in same cycle as ack with full buffer -> o_valid=0 next cycle, no stale instruction ever emitted.
REQ-035 Fetch from 32'hFFFF_FFFC -> next o_imem_addr=32'h0000_0000.
REQ-036 Assert i_rst_n=0 during outstanding request, ack during reset and in IDLE -> no o_valid, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// PC step and the fetch FSM state encoding.
package instruction_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Two-entry FIFO holding fetched {instruction, pc} pairs for the decode stage.
// Flush empties it in one cycle; push and pop in the same cycle both apply.
module fetch_buffer
  import instruction_fetch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [1:0]      count_o,
  output logic [XLEN-1:0] data_o,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] data_q [2];
  logic [XLEN-1:0] pc_q   [2];
  logic            rd_ptr_q;
  logic            wr_ptr_q;
  logic [1:0]      count_q;
  logic            pop_ok;
  logic            push_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      pc_q[0]   <= '0;
      pc_q[1]   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        data_q[wr_ptr_q] <= data_i;
        pc_q[wr_ptr_q]   <= pc_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign count_o = count_q;
  assign data_o  = data_q[rd_ptr_q];
  assign pc_o    = pc_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues word fetches to instruction memory, buffers up to
// two results for decode, and handles redirects with or without a request in flight.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic [XLEN-1:0] o_imem_addr,
  output logic            o_imem_req,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid,
  input  logic            i_ready
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] redir_pc;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic            flush;
  logic [2:0]      occ_push;
  logic [2:0]      occ_hold;

  assign redir_pc = align_pc(i_redirect_pc);
  assign pop      = o_valid && i_ready;
  // Occupancy after this cycle, with and without an accepted fetch result.
  assign occ_push = {1'b0, count} + 3'd1 - {2'b00, pop};
  assign occ_hold = {1'b0, count} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (i_redirect) begin
          flush = 1'b1;
          if (i_imem_ack) begin
            pc_d = redir_pc;
          end else begin
            tgt_d   = redir_pc;
            state_d = DRAIN;
          end
        end else if (i_imem_ack) begin
          push = 1'b1;
          pc_d = pc_q + PC_INC;
          if (occ_push >= 3'd2) state_d = STALL;
        end
      end
      STALL: begin
        if (i_redirect) begin
          flush   = 1'b1;
          pc_d    = redir_pc;
          state_d = FETCH;
        end else if (occ_hold < 3'd2) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // The old request must complete before the new target can be issued.
        if (i_redirect) begin
          flush = 1'b1;
          tgt_d = redir_pc;
        end
        if (i_imem_ack) begin
          pc_d    = i_redirect ? redir_pc : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign o_imem_addr = pc_q;
  assign o_imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign o_valid     = (count != 2'd0);

  fetch_buffer u_buf (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (i_imem_rdata),
    .pc_i    (pc_q),
    .count_o (count),
    .data_o  (o_instruction),
    .pc_o    (o_pc)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: reset/streaming vector tables, directed redirect,
// wrap and reset-abort sequences, then random traffic against a queue-based model.
module tb_instruction_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] o_imem_addr;
  logic        o_imem_req;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        i_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_addr   (o_imem_addr),
    .o_imem_req    (o_imem_req),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_valid       (o_valid),
    .i_ready       (i_ready)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          do_rst;
    bit          ack;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  vec_t tbl [15];

  // Reference model state
  bit          m_started;
  bit          m_req;
  bit          m_drain;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  ent_t        mq [$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic vec_t mk(input bit r, input bit ack, input bit redir, input logic [31:0] rpc,
                              input bit rdy, input bit er, input logic [31:0] ea,
                              input bit ev, input logic [31:0] ep);
    vec_t v;
    v.do_rst = r; v.ack = ack; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit ack, input logic [31:0] rd, input bit redir,
                       input logic [31:0] rpc, input bit rdy);
    i_imem_ack    = ack;
    i_imem_rdata  = rd;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_ready       = rdy;
  endtask

  task automatic expect_out(input string tag, input bit req, input logic [31:0] addr,
                            input bit vld, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_req"},   {31'b0, o_imem_req}, {31'b0, req});
    chk({tag, "_addr"},  o_imem_addr, addr);
    chk({tag, "_valid"}, {31'b0, o_valid}, {31'b0, vld});
    if (vld) begin
      chk({tag, "_pc"},    o_pc, pc);
      chk({tag, "_instr"}, o_instruction, ins);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge i_clk);
    expect_out("rst", 1'b0, 32'h0, 1'b0, '0, '0);
    chk("rst_instr", o_instruction, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    i_rst_n = 1'b1;
  endtask

  task automatic hs(input string tag, input bit ack, input logic [31:0] rd, input bit redir,
                    input logic [31:0] rpc, input bit rdy, input bit req,
                    input logic [31:0] addr, input bit vld, input logic [31:0] pc);
    drive(ack, rd, redir, rpc, rdy);
    expect_out(tag, req, addr, vld, pc, instr_of(pc));
    tick();
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_req     = 1'b0;
    m_drain   = 1'b0;
    m_pc      = 32'h0;
    m_tgt     = 32'h0;
    mq.delete();
  endtask

  task automatic model_step(input bit ack, input logic [31:0] rd, input bit redir,
                            input logic [31:0] rpc, input bit rdy);
    bit          pop;
    logic [31:0] a;
    ent_t        e;
    a   = {rpc[31:2], 2'b00};
    pop = (mq.size() > 0) && rdy;
    if (!m_started) begin
      m_started = 1'b1;
      m_req     = 1'b1;
      return;
    end
    if (redir) begin
      mq.delete();
      if (m_drain) begin
        m_tgt = a;
        if (ack) begin m_pc = a; m_drain = 1'b0; end
      end else if (m_req) begin
        if (ack) m_pc = a;
        else begin m_tgt = a; m_drain = 1'b1; end
      end else begin
        m_pc  = a;
        m_req = 1'b1;
      end
      return;
    end
    if (pop) void'(mq.pop_front());
    if (m_drain) begin
      if (ack) begin m_pc = m_tgt; m_drain = 1'b0; end
    end else if (m_req) begin
      if (ack) begin
        e.instr = rd;
        e.pc    = m_pc;
        mq.push_back(e);
        m_pc  = m_pc + 32'd4;
        m_req = (mq.size() < 2);
      end
    end else begin
      m_req = (mq.size() < 2);
    end
  endtask

  initial begin
    // Streaming at one per cycle, then back-pressure filling both entries.
    tbl[0]  = mk(1, 1, 0, 0, 1, 0, 32'h00, 0, 32'h0);
    tbl[1]  = mk(0, 1, 0, 0, 1, 1, 32'h00, 0, 32'h0);
    tbl[2]  = mk(0, 1, 0, 0, 1, 1, 32'h04, 1, 32'h0);
    tbl[3]  = mk(0, 1, 0, 0, 1, 1, 32'h08, 1, 32'h4);
    tbl[4]  = mk(0, 1, 0, 0, 1, 1, 32'h0C, 1, 32'h8);
    tbl[5]  = mk(0, 1, 0, 0, 1, 1, 32'h10, 1, 32'hC);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 32'h00, 0, 32'h0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 1, 32'h00, 0, 32'h0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 1, 32'h04, 1, 32'h0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 32'h08, 1, 32'h0);
    tbl[10] = mk(0, 0, 0, 0, 1, 0, 32'h08, 1, 32'h0);
    tbl[11] = mk(0, 0, 0, 0, 1, 1, 32'h08, 1, 32'h4);
    tbl[12] = mk(0, 1, 0, 0, 1, 1, 32'h08, 0, 32'h0);
    tbl[13] = mk(0, 0, 0, 0, 1, 1, 32'h0C, 1, 32'h8);
    tbl[14] = mk(0, 0, 0, 0, 1, 1, 32'h0C, 0, 32'h0);

    @(negedge i_clk);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].do_rst) do_reset();
      drive(tbl[i].ack, instr_of(tbl[i].e_addr), tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                 tbl[i].e_pc, instr_of(tbl[i].e_pc));
      tick();
    end

    // Redirect with the request outstanding; ack arrives three cycles later.
    do_reset();
    hs("drn_idle", 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    hs("drn_f0",   1, instr_of(32'h0), 0, 0, 0, 1, 32'h0, 0, 0);
    hs("drn_redir", 0, 0, 1, 32'h0000_0103, 0, 1, 32'h4, 1, 32'h0);
    hs("drn_w1",   0, 0, 0, 0, 0, 1, 32'h4, 0, 0);
    hs("drn_w2",   0, 0, 0, 0, 0, 1, 32'h4, 0, 0);
    hs("drn_ack",  1, 32'hDEAD_BEEF, 0, 0, 1, 1, 32'h4, 0, 0);
    hs("drn_new",  1, instr_of(32'h100), 0, 0, 1, 1, 32'h100, 0, 0);
    hs("drn_out",  0, 0, 0, 0, 1, 1, 32'h104, 1, 32'h100);

    // Redirect coinciding with an ack, then with a full buffer in stall.
    do_reset();
    hs("rda_idle", 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    hs("rda_f0",   1, instr_of(32'h0), 0, 0, 0, 1, 32'h0, 0, 0);
    hs("rda_rd1",  1, instr_of(32'h4), 1, 32'h0000_0201, 1, 1, 32'h4, 1, 32'h0);
    hs("rda_post1", 1, instr_of(32'h200), 0, 0, 0, 1, 32'h200, 0, 0);
    hs("rda_fill", 1, instr_of(32'h204), 0, 0, 0, 1, 32'h204, 1, 32'h200);
    hs("rda_rd2",  1, instr_of(32'h208), 1, 32'h0000_0300, 1, 0, 32'h208, 1, 32'h200);
    hs("rda_post2", 0, 0, 0, 0, 1, 1, 32'h300, 0, 0);
    hs("rda_post3", 0, 0, 0, 0, 1, 1, 32'h300, 0, 0);

    // Address wrap at the top of memory.
    do_reset();
    hs("wrp_idle", 0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    hs("wrp_rd",   1, instr_of(32'h0), 1, 32'hFFFF_FFFF, 1, 1, 32'h0, 0, 0);
    hs("wrp_top",  1, instr_of(32'hFFFF_FFFC), 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    hs("wrp_zero", 0, 0, 0, 0, 1, 1, 32'h0, 1, 32'hFFFF_FFFC);

    // Reset asserted while a request is outstanding; acks during and after reset.
    do_reset();
    hs("rab_idle", 0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    hs("rab_f0",   1, instr_of(32'h0), 0, 0, 1, 1, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 1);
    expect_out("rab_pend", 1, 32'h4, 1, 32'h0, instr_of(32'h0));
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    drive(1, 32'h1234_5678, 0, 0, 1);
    @(negedge i_clk);
    expect_out("rab_inrst", 0, 32'h0, 0, 0, 0);
    tick();
    expect_out("rab_inrst2", 0, 32'h0, 0, 0, 0);
    i_rst_n = 1'b1;
    hs("rab_idleack", 1, 32'h1234_5678, 0, 0, 1, 0, 32'h0, 0, 0);
    hs("rab_fetch", 0, 0, 0, 0, 1, 1, 32'h0, 0, 0);
    hs("rab_f1",   1, instr_of(32'h0), 0, 0, 1, 1, 32'h0, 0, 0);
    hs("rab_out",  0, 0, 0, 0, 1, 1, 32'h4, 1, 32'h0);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      bit          ack, redir, rdy;
      logic [31:0] rd, rpc;
      ack   = ($urandom_range(0, 3) != 0);
      rd    = $urandom;
      redir = ($urandom_range(0, 11) == 0);
      rpc   = $urandom;
      rdy   = ($urandom_range(0, 2) != 0);
      drive(ack, rd, redir, rpc, rdy);
      expect_out("rnd", m_req, m_pc, (mq.size() > 0),
                 (mq.size() > 0) ? mq[0].pc : 32'h0,
                 (mq.size() > 0) ? mq[0].instr : 32'h0);
      @(posedge i_clk);
      model_step(ack, rd, redir, rpc, rdy);
      @(negedge i_clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
